// File: rtl/mul8_pkg.sv
// Shared definitions for the mul8_seq shift-and-add multiplier: FSM state
// encodings, operand and iteration constants, and an absolute-value helper
// for signed mode (macro MUL8_SEQ_SIGNED_EN).
package mul8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_W    = 8;
  localparam int MUL_ITER = 8;
  localparam int CNT_W    = $clog2(MUL_ITER);

  // Magnitude of an 8-bit two's-complement value; -128 maps to 0x80.
  function automatic logic [MUL_W-1:0] abs8(input logic [MUL_W-1:0] v);
    return v[MUL_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul8_seq_add8.sv
// Add8: 8-bit ripple-carry adder used for the per-iteration partial-product add.
module Add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] carry;

  // Full-adder chain, carry rippling from bit 0 to bit 7.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments and a default for
    // every output first, so no latch is inferred.
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[8];

endmodule

// File: rtl/mul8_seq.sv
// mul8_seq: sequential 8x8 shift-and-add multiplier. One accept edge, eight
// RUN iterations, then a one-cycle DONE with the product registered on P.
// Optional signed mode (tc port) is enabled by defining MUL8_SEQ_SIGNED_EN.
module mul8_seq
  import mul8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MUL_W-1:0] A,
  input  logic [MUL_W-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [15:0]      P
`ifdef MUL8_SEQ_SIGNED_EN
  ,
  input  logic             tc
`endif
);

  state_t           state;
  logic [MUL_W-1:0] mcand;
  logic [MUL_W-1:0] acc_hi;
  logic [MUL_W-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic [MUL_W-1:0] addend;
  logic [MUL_W-1:0] sum;
  logic             sum_c;
  logic [15:0]      prod_next;
`ifdef MUL8_SEQ_SIGNED_EN
  logic             neg;
`endif

  // Multiplicand only contributes when the current multiplier bit is set.
  assign addend = acc_lo[0] ? mcand : '0;

  Add8 u_add8 (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (sum_c)
  );

  // Accumulator after this iteration's add and right shift.
  assign prod_next = {sum_c, sum, acc_lo[MUL_W-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Control FSM and datapath registers; reset clears every register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the pre-edge values regardless of statement order.
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      P      <= '0;
`ifdef MUL8_SEQ_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
`ifdef MUL8_SEQ_SIGNED_EN
            mcand  <= tc ? abs8(A) : A;
            acc_lo <= tc ? abs8(B) : B;
            neg    <= tc & (A[MUL_W-1] ^ B[MUL_W-1]);
`else
            mcand  <= A;
            acc_lo <= B;
`endif
            acc_hi <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= prod_next;
          cnt              <= cnt + 1'b1;
          if (cnt == CNT_W'(MUL_ITER - 1)) begin
`ifdef MUL8_SEQ_SIGNED_EN
            P <= neg ? (~prod_next + 1'b1) : prod_next;
`else
            P <= prod_next;
`endif
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq.sv
// Directed testbench for mul8_seq. Expected products are hand-computed.
// Signed-mode vectors run only when MUL8_SEQ_SIGNED_EN is defined.
module tb_mul8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] P;
`ifdef MUL8_SEQ_SIGNED_EN
  logic        tc;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int done_count = 0;

  mul8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
`ifdef MUL8_SEQ_SIGNED_EN
    ,
    .tc    (tc)
`endif
  );

  always #5 clk = ~clk;

  // Count done pulses mid-cycle so each one-cycle pulse is seen once.
  always @(negedge clk) if (done === 1'b1) done_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done; 'already' RUN edges have elapsed since accept. Checks the
  // edge count, busy throughout, and the product.
  task automatic wait_done(input string tag, input int already, input logic [15:0] exp);
    int n = already;
    bit busy_ok = 1'b1;
    while (done !== 1'b1 && n < already + 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_P"}, P, exp);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int d0 = done_count;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0; A = 8'h5A; B = 8'hA5;
    check({tag, "_busy_accept"}, busy, 1);
    wait_done(tag, 0, exp);
    tick();
    check({tag, "_done_low"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_one_done"}, done_count - d0, 1);
  endtask

  initial begin
    int d0;
    int last;
    int seen;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
`ifdef MUL8_SEQ_SIGNED_EN
    tc = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_P", P, 16'h0000);

    run_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    run_op("zero", 8'h00, 8'hAB, 16'h0000);
    run_op("d_b", 8'h0D, 8'h0B, 16'h008F);

    // Start pulse mid-operation must be ignored.
    d0 = done_count;
    A = 8'h12; B = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore_start", 3, 16'h03A8);
    repeat (12) tick();
    check("ignore_one_done", done_count - d0, 1);
    check("ignore_idle", busy, 0);

    // Reset in the middle of RUN aborts the operation.
    d0 = done_count;
    A = 8'h55; B = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_P", P, 16'h0000);
    repeat (12) tick();
    check("abort_no_done", done_count - d0, 0);
    check("abort_P_held", P, 16'h0000);

    // Held start: back-to-back operations every 10 cycles.
    A = 8'h02; B = 8'h03; start = 1'b1;
    last = -1; seen = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done === 1'b1) begin
        check("held_P", P, 16'h0006);
        if (last >= 0) check("held_period", i - last, 10);
        else check("held_first", i, 9);
        last = i;
        seen++;
      end
    end
    start = 1'b0;
    check("held_count", seen, 3);
    repeat (3) tick();

`ifdef MUL8_SEQ_SIGNED_EN
    tc = 1'b1;
    run_op("s_80_ff", 8'h80, 8'hFF, 16'h0080);
    run_op("s_fd_05", 8'hFD, 8'h05, 16'hFFF1);
    run_op("s_80_80", 8'h80, 8'h80, 16'h4000);
    tc = 1'b0;
    run_op("u_80_ff", 8'h80, 8'hFF, 16'h7F80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
